// File: rtl/mem_copy_engine.sv
// mem_copy_engine: owns the data memory port while busy and copies `length`
// words from src_base to dst_base, one READ and one WRITE cycle per word.
// The copy runs descending when the destination overlaps the tail of the
// source, so no source word is overwritten before it has been read.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   start                 copy request, sampled only in IDLE
//   src_base, dst_base    first source / destination word address
//   length                number of words to copy
//   busy                  high in READ and WRITE
//   done                  one-cycle pulse in DONE
//   words_copied          words written in the current or last transfer
//   mem_A, mem_WD, mem_WE memory address, write data, write enable (registered)
//   mem_RD                memory read data, combinational from mem_A
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_copied,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, mem_a_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d, wc_d, idx_inc;
  logic              desc_q, desc_d, desc_in;
  logic [DATA_W-1:0] mem_wd_d;
  logic              busy_d, done_d, mem_we_d;

  // Offset of the word handled at a given index, honouring copy direction.
  function automatic logic [LEN_W-1:0] word_off(input logic desc,
                                                input logic [LEN_W-1:0] len,
                                                input logic [LEN_W-1:0] idx);
    return desc ? LEN_W'(len - LEN_W'(1) - idx) : idx;
  endfunction

  // Destination starts inside the source block: walk from the top down.
  assign desc_in = (dst_base > src_base) &&
                   (dst_base < ADDR_W'(src_base + ADDR_W'(length)));
  assign idx_inc = LEN_W'(idx_q + LEN_W'(1));

  // State, latched transfer parameters and all port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      desc_q       <= 1'b0;
      words_copied <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_A        <= '0;
      mem_WD       <= '0;
      mem_WE       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      desc_q       <= desc_d;
      words_copied <= wc_d;
      busy         <= busy_d;
      done         <= done_d;
      mem_A        <= mem_a_d;
      mem_WD       <= mem_wd_d;
      mem_WE       <= mem_we_d;
    end
  end

  // Next state and next registered outputs; mem_WD doubles as the data register.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    idx_d    = idx_q;
    desc_d   = desc_q;
    wc_d     = words_copied;
    mem_wd_d = mem_WD;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    mem_we_d = 1'b0;
    mem_a_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_base;
          dst_d  = dst_base;
          len_d  = length;
          desc_d = desc_in;
          idx_d  = '0;
          wc_d   = '0;
          if (length == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            busy_d  = 1'b1;
            mem_a_d = ADDR_W'(src_base + ADDR_W'(word_off(desc_in, length, '0)));
          end
        end
      end
      S_READ: begin
        state_d  = S_WRITE;
        mem_wd_d = mem_RD;
        busy_d   = 1'b1;
        mem_we_d = 1'b1;
        mem_a_d  = ADDR_W'(dst_q + ADDR_W'(word_off(desc_q, len_q, idx_q)));
      end
      S_WRITE: begin
        idx_d = idx_inc;
        wc_d  = LEN_W'(words_copied + LEN_W'(1));
        if (idx_inc == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_READ;
          busy_d  = 1'b1;
          mem_a_d = ADDR_W'(src_q + ADDR_W'(word_off(desc_q, len_q, idx_inc)));
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a 32-word memory (word i = i at time zero, not
// cleared by rst) serves the engine; expected reads and writes are queued when
// a transfer is launched and matched as the engine drives the port.
module tb_mem_copy_engine;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_base = '0;
  logic [ADDR_W-1:0] dst_base = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy, done, mem_WE;
  logic [LEN_W-1:0]  words_copied;
  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD, mem_RD;

  logic [DATA_W-1:0] mem [32];
  logic [DATA_W-1:0] model_mem [32];

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base),
    .dst_base(dst_base), .length(length), .busy(busy), .done(done),
    .words_copied(words_copied), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  assign mem_RD = mem[mem_A[4:0]];
  always @(posedge clk) if (mem_WE) mem[mem_A[4:0]] <= mem_WD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Port monitor, mid-cycle: a busy cycle without WE is a read, with WE a write.
  always @(negedge clk) begin : port_mon
    wr_t e;
    if (rst && mem_WE) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 32'(exp_wr.size()), 32'd1);
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", mem_A, e.a);
        check("wr_data", mem_WD, e.d);
      end
    end else if (rst && busy) begin
      if (exp_rd.size() == 0) check("rd_unexpected", 32'(exp_rd.size()), 32'd1);
      else check("rd_addr", mem_A, exp_rd.pop_front());
    end
  end

  // Reference copy: queue nrd reads and nwr writes, apply committed writes.
  task automatic push_expected(input logic [31:0] s, input logic [31:0] d,
                               input int len, input int nwr, input int nrd);
    logic        desc;
    logic [31:0] k, ra, wa, sum;
    sum  = s + 32'(len);
    desc = (d > s) && (d < sum);
    for (int i = 0; i < len; i++) begin
      k  = desc ? 32'(len - 1 - i) : 32'(i);
      ra = s + k;
      wa = d + k;
      if (i < nrd) exp_rd.push_back(ra);
      if (i < nwr) begin
        exp_wr.push_back('{a: wa, d: model_mem[ra[4:0]]});
        model_mem[wa[4:0]] = model_mem[ra[4:0]];
      end
    end
  endtask

  // Launch a transfer from IDLE and follow it to the cycle after done.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input int len, input bit inject);
    int we_cnt, bad;
    push_expected(s, d, len, len, len);
    src_base = s;
    dst_base = d;
    length   = LEN_W'(len);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    src_base = $urandom;
    dst_base = $urandom;
    length   = LEN_W'($urandom);
    we_cnt   = 0;
    bad      = 0;
    if (len == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
    end else begin
      for (int c = 0; c < 2 * len; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        if (mem_WE) we_cnt++;
        if (done || !busy) bad++;
        if (inject && c == 3) begin
          start = 1'b1; src_base = 32'd8; dst_base = 32'd24; length = LEN_W'(4);
        end
        if (inject && c == 4) start = 1'b0;
      end
      @(posedge clk); #1;
      check("done_at_2len", 32'(done), 32'd1);
      check("busy_in_done", 32'(busy), 32'd0);
      check("we_count", 32'(we_cnt), 32'(len));
      check("busy_window", 32'(bad), 32'd0);
    end
    check("words_copied", 32'(words_copied), 32'(len));
    @(posedge clk); #1;
    check("done_pulse_end", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_addr", mem_A, 32'd0);
    check("wr_drained", 32'(exp_wr.size()), 32'd0);
    check("rd_drained", 32'(exp_rd.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]       = DATA_W'(i);
      model_mem[i] = DATA_W'(i);
    end

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(mem_WE), 32'd0);
    check("rst_addr", mem_A, 32'd0);
    check("rst_wd", mem_WD, 32'd0);
    check("rst_words", 32'(words_copied), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Basic copy with a start pulse injected mid-transfer, then an immediate restart.
    run_copy(32'd0, 32'd16, 4, 1'b1);
    for (int i = 0; i < 4; i++) check($sformatf("basic_mem%0d", 16 + i), mem[16 + i], 32'(i));
    run_copy(32'd24, 32'd12, 2, 1'b0);
    check("restart_mem12", mem[12], 32'd24);
    check("restart_mem13", mem[13], 32'd25);

    // Zero-length request.
    run_copy(32'd5, 32'd9, 0, 1'b0);

    // Overlapping forward move must run descending.
    run_copy(32'd2, 32'd4, 4, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("ovl_mem%0d", 4 + i), mem[4 + i], 32'(2 + i));
    check("ovl_mem2", mem[2], 32'd2);
    check("ovl_mem3", mem[3], 32'd3);

    // Abort during the second WRITE: only the first word lands.
    push_expected(32'd0, 32'd20, 4, 1, 2);
    src_base = 32'd0; dst_base = 32'd20; length = LEN_W'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_abort_we", 32'(mem_WE), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_we", 32'(mem_WE), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_words", 32'(words_copied), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_wr_q", 32'(exp_wr.size()), 32'd0);
    check("abort_rd_q", 32'(exp_rd.size()), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort_mem20", mem[20], 32'd0);
    for (int i = 21; i < 24; i++) check($sformatf("abort_mem%0d", i), mem[i], 32'(i));

    // Source address wraps past all-ones.
    run_copy(32'hFFFF_FFFE, 32'd8, 3, 1'b0);
    check("wrap_mem8", mem[8], 32'd30);
    check("wrap_mem9", mem[9], 32'd31);
    check("wrap_mem10", mem[10], 32'd0);

    for (int i = 0; i < 32; i++) check($sformatf("final_mem%0d", i), mem[i], model_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
